perf_cnt_mmap: RTL and testbench
================================

Name: perf_cnt_mmap

Overview:
Parametrised, memory-mapped performance-counter bank for the branch-predictor evaluation path.
- Provides NUM_CNT event counters of configurable width (branch, hit, mispredict, ...), a free-running cycle timer, and a 16-bit LFSR.
- All are readable and controllable over the 16-bit data-memory bus.
- Adds wrap/saturate mode, sticky overflow flags with interrupt, global enable/clear, and atomic wide-counter reads via a high-half shadow register.

Parameters:
NUM_CNT, 3, number of event counters (1..32)
CNT_W, 16, width of each event counter and the timer (16..32)
BASE_ADDR, 16'hC000, bus base address; must be 64-word aligned

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset; asynchronous, active-high
inc  in  NUM_CNT  per-counter increment strobe; bit i increments counter i
addr  in  16  bus word address
re  in  1  bus read strobe
we  in  1  bus write strobe
wdata  in  16  bus write data
rdata  out  16  registered read data
rdata_vld  out  1  high one cycle after an accepted read
ovf_irq  out  1  level interrupt = CTRL.irq_en & (|STATUS)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high, on port rst.
- Reset values:
  - All counters, timer, shadow, STATUS, rdata, rdata_vld and ovf_irq = 0.
  - CTRL = 16'h0001 (enabled, wrap mode, irq off).
  - LFSR = 16'hACE1.
- Address decode: hit when addr[15:6] == BASE_ADDR[15:6]; offset = addr[5:0]. Accesses that miss the decode are ignored: no rdata_vld, no write.
- Register map (offsets):
  - 0 CTRL: bit0 en, bit1 sat, bit2 clr, bit3 irq_en. Read/write. clr is self-clearing and always reads 0.
  - 1 STATUS: bits[NUM_CNT-1:0] counter overflow, bit NUM_CNT timer overflow. Sticky; write-1-to-clear.
  - 2 LFSR: read returns current value. A write of a nonzero value loads the seed; a write of zero is ignored.
  - 3 SHADOW: read-only. Returns the high half captured at the last counter/timer read.
  - 4+i counter i low: read-only. Returns cnt_i[15:0]; in the same cycle SHADOW <= zero-extended cnt_i[CNT_W-1:16].
  - 4+NUM_CNT timer low: read-only, same shadow capture as counters.
  - Any other offset reads 16'h0000; writes to it are ignored.
- Read latency: exactly 1 cycle. rdata and rdata_vld are registered from the re cycle. rdata holds its value until the next read.
- SHADOW capture: uses the value at the re cycle, i.e. the same value that feeds rdata. The snapshot is atomic. When CNT_W == 16, SHADOW always reads 0.
- Simultaneous re and we to the same register: the read returns the pre-write value.
- Counting (only while CTRL.en = 1):
  - Counter i += 1 on each cycle inc[i] = 1.
  - Timer += 1 every cycle.
  - LFSR steps every cycle: Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left, new bit0 = b15^b13^b12^b10.
  - While en = 0 all values freeze; inc is ignored.
- Overflow:
  - Wrap mode (sat = 0): max + 1 -> 0, and the STATUS bit is set.
  - Saturate mode (sat = 1): the counter holds at 2^CNT_W-1; the STATUS bit is set on the increment attempted at max.
- CTRL write with clr = 1: next cycle all counters, timer and SHADOW are 0. STATUS and LFSR are unaffected. Clear wins over a simultaneous inc; the remaining CTRL bits are written normally.
- STATUS W1C coinciding with a new overflow on the same bit: set wins.
- ovf_irq is registered; it reflects the STATUS/CTRL state one cycle after it changes.
- Reset asserted mid-operation (including during a pending read) immediately forces all reset values. rdata_vld is not produced for the interrupted read.

Decomposition:
- Package perf_cnt_pkg:
  - offset constants CTRL/STATUS/LFSR/SHADOW/CNT_BASE
  - CTRL bit indices
  - LFSR_SEED 16'hACE1 and the tap mask
  - a packed ctrl_t struct
- Sub-module perf_counter:
  - inputs: clk, rst, en, inc, clr, sat
  - outputs: cnt[CNT_W-1:0], ovf pulse
  - instantiated NUM_CNT times, plus once for the timer with inc tied to 1.

Test Plan:
1. Reset, then read offsets 0/1/2 -> rdata = 16'h0001, 16'h0000, 16'hACE1. rdata_vld is high exactly 1 cycle after each re.
2. CNT_W = 20, sat = 0: pulse inc[0] 70000 times, read offset 4 then offset 3 -> rdata = 16'h1170, then SHADOW = 16'h0001. Between the two reads, inc[0] continues to toggle; the SHADOW value is unchanged.
3. CNT_W = 16, sat = 0: 65537 increments on counter 1 -> counter = 1, STATUS bit1 = 1. Set irq_en -> ovf_irq = 1 one cycle later. Write STATUS 16'h0002 -> STATUS = 0 and ovf_irq drops.
4. sat = 1: 65540 increments on counter 2 -> counter = 16'hFFFF, STATUS bit2 = 1. A W1C in the same cycle as another increment at max -> bit stays 1.
5. Write CTRL 16'h0005 while inc = all ones -> all counters and timer = 0 next cycle, en stays 1. Write CTRL 16'h0000 -> timer, counters and LFSR frozen over 10 cycles.
6. Write LFSR 16'h0000 -> value keeps stepping from its current state. Write 16'h0001 -> the next reads show the sequence 16'h0001, 16'h0002, 16'h0004 ... per the polynomial. Assert rst mid-read -> no rdata_vld; all values at reset.

Source files
------------

// File: rtl/perf_cnt_pkg.sv
// Shared definitions for the memory-mapped performance counter bank:
// register offsets, control bit positions, LFSR constants and helpers.
package perf_cnt_pkg;

    localparam logic [5:0] OFF_CTRL     = 6'd0;
    localparam logic [5:0] OFF_STATUS   = 6'd1;
    localparam logic [5:0] OFF_LFSR     = 6'd2;
    localparam logic [5:0] OFF_SHADOW   = 6'd3;
    localparam logic [5:0] OFF_CNT_BASE = 6'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_SAT    = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // taps b15, b13, b12, b10 for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic irq_en;
        logic sat;
        logic en;
    } ctrl_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Single event counter with wrap/saturate behaviour, synchronous clear
// and a one-cycle overflow pulse on the increment attempted at max.
module perf_counter
    import perf_cnt_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    input  logic             sat,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic at_max;

    assign at_max = &cnt;
    // clear wins over an increment, so it also suppresses the overflow
    assign ovf    = en & inc & at_max & ~clr;

    // count enabled increments; hold at max in saturate mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && inc && !(sat && at_max)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/perf_cnt_mmap.sv
// Memory-mapped bank of event counters, cycle timer and LFSR with sticky
// overflow status, interrupt, and atomic high-half capture for wide reads.
module perf_cnt_mmap
    import perf_cnt_pkg::*;
#(
    parameter int          NUM_CNT   = 3,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] BASE_ADDR = 16'hC000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CNT-1:0] inc,
    input  logic [15:0]        addr,
    input  logic               re,
    input  logic               we,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata,
    output logic               rdata_vld,
    output logic               ovf_irq
);

    localparam logic [5:0] CNT_LAST = 6'(NUM_CNT);

    ctrl_t              ctrl;
    logic [NUM_CNT:0]   status;
    logic [NUM_CNT:0]   w1c;
    logic [NUM_CNT:0]   ovf;
    logic [15:0]        lfsr;
    logic [15:0]        shadow;
    logic [15:0]        shadow_val;
    logic [15:0]        st_rd;
    logic [15:0]        rd_val;
    logic [CNT_W-1:0]   cnt [NUM_CNT+1];
    logic [CNT_W-1:0]   cnt_sel;
    logic [5:0]         off;
    logic [5:0]         cnt_idx;
    logic               hit;
    logic               rd_en;
    logic               wr_en;
    logic               wr_ctrl;
    logic               wr_status;
    logic               wr_lfsr;
    logic               is_cnt;
    logic               clr;

    assign hit       = addr[15:6] == BASE_ADDR[15:6];
    assign off       = addr[5:0];
    assign rd_en     = re & hit;
    assign wr_en     = we & hit;
    assign wr_ctrl   = wr_en && off == OFF_CTRL;
    assign wr_status = wr_en && off == OFF_STATUS;
    assign wr_lfsr   = wr_en && off == OFF_LFSR;
    assign clr       = wr_ctrl & wdata[CTRL_CLR];
    assign cnt_idx   = off - OFF_CNT_BASE;
    assign is_cnt    = off >= OFF_CNT_BASE && cnt_idx <= CNT_LAST;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .en  (ctrl.en),
            .inc (inc[i]),
            .clr (clr),
            .sat (ctrl.sat),
            .cnt (cnt[i]),
            .ovf (ovf[i])
        );
    end

    perf_counter #(.CNT_W(CNT_W)) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (ctrl.en),
        .inc (1'b1),
        .clr (clr),
        .sat (ctrl.sat),
        .cnt (cnt[NUM_CNT]),
        .ovf (ovf[NUM_CNT])
    );

    if (CNT_W > 16) begin : g_wide
        assign shadow_val = 16'(cnt_sel[CNT_W-1:16]);
    end else begin : g_narrow
        assign shadow_val = '0;
    end

    // read mux, status view and write-1-to-clear mask
    always_comb begin
        cnt_sel = '0;
        st_rd   = '0;
        w1c     = '0;
        rd_val  = '0;
        for (int i = 0; i <= NUM_CNT; i++) begin
            if (cnt_idx == 6'(i)) cnt_sel = cnt[i];
        end
        for (int i = 0; i <= NUM_CNT && i < 16; i++) begin
            st_rd[i] = status[i];
            w1c[i]   = wr_status & wdata[i];
        end
        case (off)
            OFF_CTRL:   rd_val = {12'h000, ctrl.irq_en, 1'b0,
                                  ctrl.sat, ctrl.en};
            OFF_STATUS: rd_val = st_rd;
            OFF_LFSR:   rd_val = lfsr;
            OFF_SHADOW: rd_val = shadow;
            default:    if (is_cnt) rd_val = cnt_sel[15:0];
        endcase
    end

    // control register; clr is a pulse and never stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= '{irq_en: 1'b0, sat: 1'b0, en: 1'b1};
        end else if (wr_ctrl) begin
            ctrl.en     <= wdata[CTRL_EN];
            ctrl.sat    <= wdata[CTRL_SAT];
            ctrl.irq_en <= wdata[CTRL_IRQ_EN];
        end
    end

    // sticky overflow flags; a new overflow beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) status <= '0;
        else     status <= (status & ~w1c) | ovf;
    end

    // LFSR: nonzero write reseeds, otherwise step while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (wr_lfsr && wdata != 16'h0000) begin
            lfsr <= wdata;
        end else if (ctrl.en) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // capture the high half alongside every counter/timer read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (clr) begin
            shadow <= '0;
        end else if (rd_en && is_cnt) begin
            shadow <= shadow_val;
        end
    end

    // registered read port; rdata holds until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata     <= '0;
            rdata_vld <= 1'b0;
        end else begin
            rdata_vld <= rd_en;
            if (rd_en) rdata <= rd_val;
        end
    end

    // registered level interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_irq <= 1'b0;
        else     ovf_irq <= ctrl.irq_en & (|status);
    end

endmodule

// File: tb/tb_perf_cnt_mmap.sv
// Directed bench: a 20-bit instance for shadow capture and a 16-bit
// instance for overflow, saturate, clear, freeze, LFSR and reset.
module tb_perf_cnt_mmap;

    localparam logic [15:0] BASE = 16'hC000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        re;
    logic        we;
    logic [2:0]  inc_a;
    logic [2:0]  inc_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic        vld_a;
    logic        vld_b;
    logic        irq_a;
    logic        irq_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    perf_cnt_mmap #(.NUM_CNT(3), .CNT_W(20), .BASE_ADDR(BASE)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc_a),
        .addr      (addr),
        .re        (re),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata_a),
        .rdata_vld (vld_a),
        .ovf_irq   (irq_a)
    );

    perf_cnt_mmap #(.NUM_CNT(3), .CNT_W(16), .BASE_ADDR(BASE)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc_b),
        .addr      (addr),
        .re        (re),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata_b),
        .rdata_vld (vld_b),
        .ovf_irq   (irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] o, input logic [15:0] d);
        addr  = {BASE[15:6], o};
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [5:0] o);
        addr = {BASE[15:6], o};
        re   = 1'b1;
        tick();
        re   = 1'b0;
    endtask

    task automatic rd_b(input string tag, input logic [5:0] o,
                        input logic [15:0] exp);
        rd(o);
        chk(tag, {16'h0, rdata_b}, {16'h0, exp});
    endtask

    initial begin
        rst   = 1'b1;
        re    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        inc_a = '0;
        inc_b = '0;
        repeat (2) tick();
        chk("rst_rdata", {16'h0, rdata_b}, 32'h0);
        chk("rst_vld", {31'h0, vld_b}, 32'h0);
        chk("rst_irq", {31'h0, irq_b}, 32'h0);
        rst = 1'b0;

        // first read lands before the LFSR has stepped
        rd_b("rst_lfsr", 6'd2, 16'hACE1);
        chk("vld_lfsr", {31'h0, vld_b}, 32'h1);
        rd_b("rst_ctrl", 6'd0, 16'h0001);
        chk("vld_ctrl", {31'h0, vld_b}, 32'h1);
        rd_b("rst_status", 6'd1, 16'h0000);
        tick();
        chk("vld_drop", {31'h0, vld_b}, 32'h0);

        addr = 16'h8002;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        chk("miss_no_vld", {31'h0, vld_b}, 32'h0);
        rd_b("unmapped", 6'h3F, 16'h0000);
        chk("unmapped_vld", {31'h0, vld_b}, 32'h1);

        // long run: A ctr0 70000, B ctr1 65537, B ctr2 65535
        wr(6'd0, 16'h0005);
        for (int i = 0; i < 70000; i++) begin
            inc_a = 3'b001;
            inc_b = {i < 65535, i < 65537, 1'b0};
            tick();
        end
        inc_a = '0;
        inc_b = '0;
        rd(6'd4);
        chk("a_cnt0_lo", {16'h0, rdata_a}, 32'h1170);
        inc_a = 3'b001;
        tick();
        tick();
        rd(6'd3);
        chk("a_shadow", {16'h0, rdata_a}, 32'h0001);
        inc_a = '0;

        rd_b("b_cnt1_wrap", 6'd5, 16'h0001);
        rd_b("b_cnt2_max", 6'd6, 16'hFFFF);
        // timer wrapped once in the run
        rd_b("b_status_a", 6'd1, 16'h000A);
        wr(6'd1, 16'h0008);
        rd_b("b_status_b", 6'd1, 16'h0002);
        chk("irq_off", {31'h0, irq_b}, 32'h0);
        wr(6'd0, 16'h0009);
        chk("irq_lag", {31'h0, irq_b}, 32'h0);
        tick();
        chk("irq_on", {31'h0, irq_b}, 32'h1);
        wr(6'd1, 16'h0002);
        chk("irq_hold", {31'h0, irq_b}, 32'h1);
        tick();
        chk("irq_drop", {31'h0, irq_b}, 32'h0);
        rd_b("b_status_clr", 6'd1, 16'h0000);

        // saturate mode
        wr(6'd0, 16'h0003);
        inc_b = 3'b100;
        repeat (5) tick();
        inc_b = '0;
        rd_b("sat_cnt2", 6'd6, 16'hFFFF);
        rd_b("sat_status", 6'd1, 16'h0004);
        inc_b = 3'b100;
        wr(6'd1, 16'h0004);
        inc_b = '0;
        rd_b("set_wins", 6'd1, 16'h0004);
        wr(6'd1, 16'h0004);
        rd_b("w1c_ok", 6'd1, 16'h0000);

        // clear beats increment
        inc_b = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wr(6'd0, 16'h0005);
            rd_b($sformatf("clr_%0d", k), 6'(4 + k), 16'h0000);
        end
        rd_b("clr_ctrl", 6'd0, 16'h0001);

        // freeze: one increment lands in the disabling cycle
        wr(6'd0, 16'h0005);
        wr(6'd0, 16'h0000);
        wr(6'd2, 16'h1234);
        repeat (10) tick();
        rd_b("frz_cnt0", 6'd4, 16'h0001);
        rd_b("frz_cnt1", 6'd5, 16'h0001);
        rd_b("frz_cnt2", 6'd6, 16'h0001);
        rd_b("frz_timer", 6'd7, 16'h0001);
        rd_b("frz_lfsr", 6'd2, 16'h1234);
        rd_b("b_shadow0", 6'd3, 16'h0000);
        inc_b = '0;

        // LFSR: zero write ignored, then seed 1 and walk
        wr(6'd0, 16'h0001);
        wr(6'd2, 16'h0000);
        rd_b("lfsr_zero_wr", 6'd2, 16'h2469);
        wr(6'd2, 16'h0001);
        rd_b("lfsr_s0", 6'd2, 16'h0001);
        rd_b("lfsr_s1", 6'd2, 16'h0002);
        rd_b("lfsr_s2", 6'd2, 16'h0004);
        rd_b("lfsr_s3", 6'd2, 16'h0008);

        // reset during a pending read
        addr = {BASE[15:6], 6'd2};
        re   = 1'b1;
        #3;
        rst  = 1'b1;
        #1;
        chk("rst_async_rdata", {16'h0, rdata_b}, 32'h0);
        @(posedge clk);
        #1;
        re   = 1'b0;
        chk("rst_mid_vld", {31'h0, vld_b}, 32'h0);
        chk("rst_mid_rdata", {16'h0, rdata_b}, 32'h0);
        rst  = 1'b0;
        rd_b("post_rst_lfsr", 6'd2, 16'hACE1);
        rd_b("post_rst_ctrl", 6'd0, 16'h0001);
        rd_b("post_rst_cnt0", 6'd4, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
